// File: rtl/tdsp_branch_seq_pkg.sv
// rtl/tdsp_branch_seq_pkg.sv - branch sequencer constants, condition codes and FSM state type
// No ports: imported by tdsp_ret_stack and tdsp_branch_seq.
package tdsp_branch_seq_pkg;

  localparam int ADDR_W_DEF      = 12;
  localparam int STACK_DEPTH_DEF = 4;

  // Opcode class nibble in ins_word[15:12] that marks a branch-class word
  localparam logic [3:0] BR_CLASS = 4'hF;

  localparam logic [3:0] COND_B    = 4'h0;
  localparam logic [3:0] COND_BZ   = 4'h1;
  localparam logic [3:0] COND_BNZ  = 4'h2;
  localparam logic [3:0] COND_BGZ  = 4'h3;
  localparam logic [3:0] COND_BGEZ = 4'h4;
  localparam logic [3:0] COND_BLZ  = 4'h5;
  localparam logic [3:0] COND_BLEZ = 4'h6;
  localparam logic [3:0] COND_BV   = 4'h7;
  localparam logic [3:0] COND_BANZ = 4'h8;
  localparam logic [3:0] COND_BIOZ = 4'h9;
  localparam logic [3:0] COND_CALL = 4'hA;
  localparam logic [3:0] COND_RET  = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_EXEC = 2'd2
  } br_state_t;

  // Codes C..F are reserved; such opcodes are swallowed without effect
  function automatic logic cond_legal(input logic [3:0] cond);
    return (cond <= COND_RET);
  endfunction

endpackage

// File: rtl/tdsp_ret_stack.sv
// rtl/tdsp_ret_stack.sv - hardware return-address stack with shift-discard on overflow
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the stack)
//   push, pop       one-cycle requests (push wins if both asserted)
//   push_data       return address to push
//   top             current top of stack, 0 when empty
//   level           occupancy 0..DEPTH
//   ovf, unf        sticky overflow / underflow flags
module tdsp_ret_stack
  import tdsp_branch_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = STACK_DEPTH_DEF,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [LVL_W-1:0]  level,
  output logic              ovf,
  output logic              unf
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  lvl_m1;

  assign full   = (level == LVL_W'(DEPTH));
  assign empty  = (level == '0);
  assign lvl_m1 = level - LVL_W'(1);
  assign top    = empty ? '0 : mem[lvl_m1[LVL_W-2:0]];

  // Entry 0 is the oldest; a push while full shifts everything down one
  // slot so the oldest return address falls off the bottom.
  always_ff @(posedge clk) begin
    if (push) begin
      if (full) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem[i] <= mem[i+1];
        end
        mem[DEPTH-1] <= push_data;
      end else begin
        mem[level[LVL_W-2:0]] <= push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      if (full) begin
        ovf <= 1'b1;
      end else begin
        level <= level + LVL_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        level <= lvl_m1;
      end
    end
  end

endmodule

// File: rtl/tdsp_branch_seq.sv
// rtl/tdsp_branch_seq.sv - branch condition evaluation and PC-load sequencer for the Tiny DSP
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ins_valid/ins_ready     handshake for opcode and target words from the decoder
//   ins_word                opcode word (F,cond,xx) or target-address word
//   pc_ret                  address after the current instruction
//   gez..bioz               accumulator / AR / BIO status flags
//   pc_load, pc_target      one-cycle PC load request and destination
//   taken                   condition result, qualifies pc_load
//   ar_dec, ov_clr          one-cycle side-effect pulses for BANZ / BV
//   stk_level, stk_ovf/unf  return stack occupancy and sticky error flags
module tdsp_branch_seq
  import tdsp_branch_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  input  logic [15:0]                  ins_word,
  input  logic [ADDR_W-1:0]            pc_ret,
  input  logic                         gez,
  input  logic                         gz,
  input  logic                         nz,
  input  logic                         z,
  input  logic                         lz,
  input  logic                         lez,
  input  logic                         ov,
  input  logic                         arnz,
  input  logic                         bioz,
  output logic                         pc_load,
  output logic [ADDR_W-1:0]            pc_target,
  output logic                         taken,
  output logic                         ar_dec,
  output logic                         ov_clr,
  output logic [$clog2(STACK_DEPTH):0] stk_level,
  output logic                         stk_ovf,
  output logic                         stk_unf
);

  br_state_t         state;
  logic [3:0]        cond_q;
  logic              res_q;
  logic [ADDR_W-1:0] pc_ret_q;

  logic [3:0]        op_cond;
  logic              is_branch_op;
  logic              cond_res;
  logic              stk_push;
  logic              stk_pop;
  logic [ADDR_W-1:0] stk_top;

  assign op_cond      = ins_word[11:8];
  assign is_branch_op = (ins_word[15:12] == BR_CLASS) && cond_legal(op_cond);

  // Ready is a pure function of state so flags never reach the handshake.
  assign ins_ready = (state != ST_EXEC);

  // Evaluated only when an opcode is accepted; the result is latched so
  // later flag changes during a stalled ADDR phase have no effect.
  always_comb begin
    cond_res = 1'b0;
    case (op_cond)
      COND_B:    cond_res = 1'b1;
      COND_BZ:   cond_res = z;
      COND_BNZ:  cond_res = nz;
      COND_BGZ:  cond_res = gz;
      COND_BGEZ: cond_res = gez;
      COND_BLZ:  cond_res = lz;
      COND_BLEZ: cond_res = lez;
      COND_BV:   cond_res = ov;
      COND_BANZ: cond_res = arnz;
      COND_BIOZ: cond_res = bioz;
      COND_CALL: cond_res = 1'b1;
      COND_RET:  cond_res = 1'b1;
      default:   cond_res = 1'b0;
    endcase
  end

  // RET pops at accept time so its target is ready for the very next cycle;
  // CALL pushes during EXEC, by which time the return address is latched.
  assign stk_pop  = (state == ST_IDLE) && ins_valid && is_branch_op && (op_cond == COND_RET);
  assign stk_push = (state == ST_EXEC) && (cond_q == COND_CALL);

  tdsp_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_ret_q),
    .top       (stk_top),
    .level     (stk_level),
    .ovf       (stk_ovf),
    .unf       (stk_unf)
  );

  // EXEC-cycle outputs are loaded on the edge that enters EXEC, so they are
  // high exactly while the FSM sits in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cond_q    <= COND_B;
      res_q     <= 1'b0;
      pc_ret_q  <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      taken     <= 1'b0;
      ar_dec    <= 1'b0;
      ov_clr    <= 1'b0;
    end else begin
      pc_load   <= 1'b0;
      pc_target <= '0;
      taken     <= 1'b0;
      ar_dec    <= 1'b0;
      ov_clr    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ins_valid && is_branch_op) begin
            cond_q <= op_cond;
            if (op_cond == COND_RET) begin
              state     <= ST_EXEC;
              pc_load   <= 1'b1;
              taken     <= 1'b1;
              pc_target <= stk_top;
            end else begin
              res_q <= cond_res;
              state <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (ins_valid) begin
            pc_ret_q  <= pc_ret;
            state     <= ST_EXEC;
            pc_load   <= 1'b1;
            taken     <= res_q;
            pc_target <= res_q ? ins_word[ADDR_W-1:0] : pc_ret;
            ar_dec    <= (cond_q == COND_BANZ);
            ov_clr    <= (cond_q == COND_BV) && res_q;
          end
        end
        ST_EXEC: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdsp_branch_seq.sv
// tb/tb_tdsp_branch_seq.sv - directed self-checking bench for tdsp_branch_seq
module tb_tdsp_branch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ins_valid;
  logic        ins_ready;
  logic [15:0] ins_word;
  logic [11:0] pc_ret;
  logic        gez, gz, nz, z, lz, lez, ov, arnz, bioz;
  logic        pc_load;
  logic [11:0] pc_target;
  logic        taken;
  logic        ar_dec;
  logic        ov_clr;
  logic [2:0]  stk_level;
  logic        stk_ovf;
  logic        stk_unf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tdsp_branch_seq #(
    .ADDR_W      (12),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_word  (ins_word),
    .pc_ret    (pc_ret),
    .gez       (gez),
    .gz        (gz),
    .nz        (nz),
    .z         (z),
    .lz        (lz),
    .lez       (lez),
    .ov        (ov),
    .arnz      (arnz),
    .bioz      (bioz),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .taken     (taken),
    .ar_dec    (ar_dec),
    .ov_clr    (ov_clr),
    .stk_level (stk_level),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Two-word branch: opcode, then target; checks the EXEC cycle and the return to IDLE.
  task automatic br2(input logic [3:0] c, input logic [15:0] tword, input logic [11:0] pr,
                     input logic et, input logic [11:0] etgt, input logic ea, input logic eo);
    ins_valid = 1'b1;
    ins_word  = {4'hF, c, 8'h00};
    tick();
    chk("addr_no_load", pc_load, 0);
    chk("addr_ready", ins_ready, 1);
    ins_word = tword;
    pc_ret   = pr;
    tick();
    ins_valid = 1'b0;
    chk("exec_pc_load", pc_load, 1);
    chk("exec_taken", taken, et);
    chk("exec_target", pc_target, etgt);
    chk("exec_ar_dec", ar_dec, ea);
    chk("exec_ov_clr", ov_clr, eo);
    chk("exec_not_ready", ins_ready, 0);
    tick();
    chk("post_no_load", pc_load, 0);
    chk("post_ready", ins_ready, 1);
  endtask

  task automatic ret1(input logic [11:0] etgt);
    ins_valid = 1'b1;
    ins_word  = 16'hFB00;
    tick();
    ins_valid = 1'b0;
    chk("ret_pc_load", pc_load, 1);
    chk("ret_taken", taken, 1);
    chk("ret_target", pc_target, etgt);
    tick();
    chk("ret_post_no_load", pc_load, 0);
  endtask

  initial begin
    reset = 1'b1;
    ins_valid = 1'b0;
    ins_word = 16'h0000;
    pc_ret = 12'h000;
    {gez, gz, nz, z, lz, lez, ov, arnz, bioz} = 9'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("rst_ready", ins_ready, 1);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_taken", taken, 0);
    chk("rst_target", pc_target, 0);
    chk("rst_ar_dec", ar_dec, 0);
    chk("rst_ov_clr", ov_clr, 0);
    chk("rst_level", stk_level, 0);
    chk("rst_ovf", stk_ovf, 0);
    chk("rst_unf", stk_unf, 0);

    // BZ taken / not taken
    z = 1'b1;
    br2(4'h1, 16'h0123, 12'h045, 1'b1, 12'h123, 1'b0, 1'b0);
    z = 1'b0;
    br2(4'h1, 16'h0123, 12'h045, 1'b0, 12'h045, 1'b0, 1'b0);

    // BANZ: ar_dec regardless of outcome
    arnz = 1'b0;
    br2(4'h8, 16'h0200, 12'h010, 1'b0, 12'h010, 1'b1, 1'b0);
    arnz = 1'b1;
    br2(4'h8, 16'h0200, 12'h010, 1'b1, 12'h200, 1'b1, 1'b0);
    arnz = 1'b0;

    // BV: ov_clr only when taken
    ov = 1'b1;
    br2(4'h7, 16'h00AB, 12'h011, 1'b1, 12'h0AB, 1'b0, 1'b1);
    ov = 1'b0;
    br2(4'h7, 16'h00AB, 12'h011, 1'b0, 12'h011, 1'b0, 1'b0);

    // Unconditional B with upper target bits set (ignored); BGEZ not taken
    br2(4'h0, 16'hA3FF, 12'h012, 1'b1, 12'h3FF, 1'b0, 1'b0);
    gz = 1'b1;
    br2(4'h4, 16'h0333, 12'h013, 1'b0, 12'h013, 1'b0, 1'b0);
    gz = 1'b0;

    // Five CALLs into a 4-deep stack
    for (int i = 1; i <= 5; i++) begin
      br2(4'hA, 16'h0300 + 16'(i), 12'(i), 1'b1, 12'h300 + 12'(i), 1'b0, 1'b0);
      chk("call_level", stk_level, (i > 4) ? 4 : i);
      chk("call_ovf", stk_ovf, (i == 5) ? 1 : 0);
    end

    // Four RETs drain 5,4,3,2; fifth underflows
    for (int k = 0; k < 4; k++) begin
      ret1(12'(5 - k));
      chk("ret_level", stk_level, 3 - k);
      chk("ret_unf_clear", stk_unf, 0);
    end
    ret1(12'h000);
    chk("unf_level", stk_level, 0);
    chk("unf_set", stk_unf, 1);

    // Flags are sampled only at opcode accept; ADDR waits indefinitely
    z = 1'b1;
    ins_valid = 1'b1;
    ins_word  = 16'hF100;
    tick();
    ins_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_no_load", pc_load, 0);
    end
    z = 1'b0;
    ins_valid = 1'b1;
    ins_word  = 16'h0155;
    pc_ret    = 12'h020;
    tick();
    ins_valid = 1'b0;
    chk("stall_pc_load", pc_load, 1);
    chk("stall_taken", taken, 1);
    chk("stall_target", pc_target, 12'h155);
    tick();

    // Reset during ADDR
    br2(4'hA, 16'h0050, 12'h021, 1'b1, 12'h050, 1'b0, 1'b0);
    chk("pre_rst_level", stk_level, 1);
    ins_valid = 1'b1;
    ins_word  = 16'hF100;
    tick();
    reset    = 1'b1;
    ins_word = 16'h0123;
    tick();
    reset     = 1'b0;
    ins_valid = 1'b0;
    chk("midrst_pc_load", pc_load, 0);
    chk("midrst_ready", ins_ready, 1);
    chk("midrst_level", stk_level, 0);
    chk("midrst_ovf", stk_ovf, 0);
    chk("midrst_unf", stk_unf, 0);
    ins_valid = 1'b1;
    ins_word  = 16'h0123;
    tick();
    ins_valid = 1'b0;
    chk("idle_target_ignored", pc_load, 0);
    tick();
    chk("idle_target_ignored2", pc_load, 0);

    // Illegal opcode swallowed
    ins_valid = 1'b1;
    ins_word  = 16'hFC00;
    tick();
    ins_valid = 1'b0;
    chk("ill_ready", ins_ready, 1);
    chk("ill_pc_load", pc_load, 0);
    chk("ill_ar_dec", ar_dec, 0);
    chk("ill_ov_clr", ov_clr, 0);
    tick();
    chk("ill_pc_load2", pc_load, 0);
    chk("ill_level", stk_level, 0);
    br2(4'h0, 16'h0444, 12'h030, 1'b1, 12'h444, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
